// File: rtl/ap_pkg.sv
// Shared encodings for the associative-processor tag unit:
// operation codes and the responder-scan FSM states.
package ap_pkg;

   typedef enum logic [1:0] {
      OP_LOAD         = 2'd0,
      OP_AND          = 2'd1,
      OP_OR           = 2'd2,
      OP_SELECT_FIRST = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/ap_match_reduce.sv
// Per-row AND of the bit-column tag outputs over the enabled columns;
// with no column enabled every row matches.
module ap_match_reduce
   import ap_pkg::*;
#(
   parameter int DATA_DEPTH = 4,
   parameter int WORD_WIDTH = 4
) (
   input  logic [DATA_DEPTH*WORD_WIDTH-1:0] tag_cell_in,
   input  logic [WORD_WIDTH-1:0]            col_en,
   output logic [DATA_DEPTH-1:0]            match
);

   always_comb begin
      match = '1;
      for (int unsigned c = 0; c < WORD_WIDTH; c++) begin
         if (col_en[c]) begin
            match = match & tag_cell_in[c*DATA_DEPTH +: DATA_DEPTH];
         end
      end
   end

endmodule

// File: rtl/ap_tag_unit.sv
// Row tag register and responder resolution: applies the requested op to
// the tag, then scans one row per cycle to publish count / first / any.
module ap_tag_unit
   import ap_pkg::*;
#(
   parameter  int DATA_DEPTH = 4,
   parameter  int WORD_WIDTH = 4,
   localparam int IW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
   localparam int CW = $clog2(DATA_DEPTH + 1)
) (
   input  logic                             clk,
   input  logic                             rstIn,
   input  logic [DATA_DEPTH*WORD_WIDTH-1:0] tag_cell_in,
   input  logic [WORD_WIDTH-1:0]            col_en,
   input  logic                             op_valid,
   input  logic [1:0]                       op,
   output logic                             op_ready,
   output logic [DATA_DEPTH-1:0]            tag,
   output logic                             any_hit,
   output logic [IW-1:0]                    first_idx,
   output logic [CW-1:0]                    hit_count,
   output logic                             done
);

   state_e                state, state_next;
   logic [DATA_DEPTH-1:0] match;
   logic [DATA_DEPTH-1:0] tag_next;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         shadow_first;
   logic [CW-1:0]         shadow_count;
   logic                  shadow_found;
   logic                  accept;
   logic                  row_hit;
   logic                  last_row;

   ap_match_reduce #(
      .DATA_DEPTH (DATA_DEPTH),
      .WORD_WIDTH (WORD_WIDTH)
   ) u_match (
      .tag_cell_in (tag_cell_in),
      .col_en      (col_en),
      .match       (match)
   );

   assign op_ready = (state == IDLE);
   assign done     = (state == DONE);
   assign accept   = op_valid && op_ready;
   assign row_hit  = tag[idx];
   assign last_row = (idx == IW'(DATA_DEPTH - 1));

   always_ff @(posedge clk) begin
      if (rstIn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept) state_next = SCAN;
         SCAN:    if (last_row) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Lowest set bit isolated with tag & -tag
   always_comb begin
      tag_next = tag;
      unique case (op_e'(op))
         OP_LOAD:         tag_next = match;
         OP_AND:          tag_next = tag & match;
         OP_OR:           tag_next = tag | match;
         OP_SELECT_FIRST: tag_next = tag & (~tag + DATA_DEPTH'(1));
         default:         tag_next = tag;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstIn) begin
         tag          <= '0;
         idx          <= '0;
         shadow_count <= '0;
         shadow_first <= '0;
         shadow_found <= 1'b0;
         hit_count    <= '0;
         first_idx    <= '0;
         any_hit      <= 1'b0;
      end else begin
         if (accept) begin
            tag          <= tag_next;
            idx          <= '0;
            shadow_count <= '0;
            shadow_first <= '0;
            shadow_found <= 1'b0;
         end
         if (state == SCAN) begin
            if (row_hit) begin
               shadow_count <= shadow_count + CW'(1);
            end
            if (row_hit && !shadow_found) begin
               shadow_first <= idx;
               shadow_found <= 1'b1;
            end
            // Last row is folded in directly so results publish on DONE entry
            if (last_row) begin
               hit_count <= shadow_count + CW'(row_hit);
               first_idx <= (row_hit && !shadow_found) ? idx : shadow_first;
               any_hit   <= shadow_found | row_hit;
            end else begin
               idx <= idx + IW'(1);
            end
         end
      end
   end

endmodule
